// File: rtl/mem_port_arbiter.sv
// Shared memory port arbiter: CPU-first with starvation bound for debug,
// plus a debug lock mode for exclusive programming bursts.
module mem_port_arbiter #(
  parameter int REGISTER_WIDTH       = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int STARVE_LIMIT         = 4,
  parameter int STARVE_CNT_WIDTH     = 3
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            cpu_req_i,
  input  logic                            cpu_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [REGISTER_WIDTH-1:0]       cpu_wdata_i,
  output logic                            cpu_gnt_o,
  output logic [REGISTER_WIDTH-1:0]       cpu_rdata_o,
  output logic                            cpu_rvalid_o,
  input  logic                            dbg_req_i,
  input  logic                            dbg_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] dbg_addr_i,
  input  logic [REGISTER_WIDTH-1:0]       dbg_wdata_i,
  input  logic                            dbg_lock_i,
  output logic                            dbg_gnt_o,
  output logic [REGISTER_WIDTH-1:0]       dbg_rdata_o,
  output logic                            dbg_rvalid_o,
  output logic                            read_en_mem_o,
  output logic                            write_en_mem_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] addr_mem_o,
  output logic [REGISTER_WIDTH-1:0]       write_data_mem_o,
  input  logic [REGISTER_WIDTH-1:0]       read_data_mem_i,
  output logic [1:0]                      owner_o
);

  typedef enum logic [1:0] {
    stIDLE = 2'd0,
    stCPU  = 2'd1,
    stDBG  = 2'd2,
    stLOCK = 2'd3
  } state_t;

  localparam logic [STARVE_CNT_WIDTH-1:0] LIMIT =
    STARVE_CNT_WIDTH'(STARVE_LIMIT);

  state_t                      state_q;
  state_t                      state_d;
  logic [STARVE_CNT_WIDTH-1:0] starve_q;
  logic [STARVE_CNT_WIDTH-1:0] starve_d;
  logic                        starved;
  logic                        cpu_win;
  logic                        dbg_win;

  assign starved = (starve_q == LIMIT);

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    state_d = stIDLE;
    if (reset_i) begin
      state_d = stIDLE;
    end else if (state_q == stLOCK && dbg_lock_i) begin
      dbg_win = dbg_req_i;
      state_d = stLOCK;
    end else begin
      // Exit cycle of a lock falls through to normal arbitration
      if (dbg_req_i && (!cpu_req_i || starved))
        dbg_win = 1'b1;
      else if (cpu_req_i)
        cpu_win = 1'b1;
      unique case (1'b1)
        cpu_win: state_d = stCPU;
        dbg_win: state_d = dbg_lock_i ? stLOCK : stDBG;
        default: state_d = stIDLE;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!dbg_req_i || dbg_win)
      starve_d = '0;
    else if (cpu_win && !starved)
      starve_d = starve_q + 1'b1;
  end

  always_comb begin
    read_en_mem_o    = 1'b0;
    write_en_mem_o   = 1'b0;
    addr_mem_o       = '0;
    write_data_mem_o = '0;
    unique case (1'b1)
      cpu_win: begin
        read_en_mem_o    = !cpu_we_i;
        write_en_mem_o   = cpu_we_i;
        addr_mem_o       = cpu_addr_i;
        write_data_mem_o = cpu_wdata_i;
      end
      dbg_win: begin
        read_en_mem_o    = !dbg_we_i;
        write_en_mem_o   = dbg_we_i;
        addr_mem_o       = dbg_addr_i;
        write_data_mem_o = dbg_wdata_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= stIDLE;
      starve_q     <= '0;
      cpu_rdata_o  <= '0;
      cpu_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
      dbg_rvalid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      cpu_rvalid_o <= cpu_win && !cpu_we_i;
      dbg_rvalid_o <= dbg_win && !dbg_we_i;
      if (cpu_win && !cpu_we_i)
        cpu_rdata_o <= read_data_mem_i;
      if (dbg_win && !dbg_we_i)
        dbg_rdata_o <= read_data_mem_i;
    end
  end

  assign cpu_gnt_o = cpu_win;
  assign dbg_gnt_o = dbg_win;
  assign owner_o   = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a small behavioural memory.
module tb_mem_port_arbiter;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       cpu_req_i, cpu_we_i;
  logic [3:0] cpu_addr_i, cpu_wdata_i;
  logic       cpu_gnt_o, cpu_rvalid_o;
  logic [3:0] cpu_rdata_o;
  logic       dbg_req_i, dbg_we_i, dbg_lock_i;
  logic [3:0] dbg_addr_i, dbg_wdata_i;
  logic       dbg_gnt_o, dbg_rvalid_o;
  logic [3:0] dbg_rdata_o;
  logic       read_en_mem_o, write_en_mem_o;
  logic [3:0] addr_mem_o, write_data_mem_o;
  logic [3:0] read_data_mem_i;
  logic [1:0] owner_o;

  logic [3:0] mem [16];
  logic [3:0] exp_cpu_q [$];
  logic [3:0] exp_dbg_q [$];
  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rdata_o(cpu_rdata_o),
    .cpu_rvalid_o(cpu_rvalid_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i),
    .dbg_addr_i(dbg_addr_i), .dbg_wdata_i(dbg_wdata_i),
    .dbg_lock_i(dbg_lock_i),
    .dbg_gnt_o(dbg_gnt_o), .dbg_rdata_o(dbg_rdata_o),
    .dbg_rvalid_o(dbg_rvalid_o),
    .read_en_mem_o(read_en_mem_o),
    .write_en_mem_o(write_en_mem_o),
    .addr_mem_o(addr_mem_o),
    .write_data_mem_o(write_data_mem_o),
    .read_data_mem_i(read_data_mem_i),
    .owner_o(owner_o)
  );

  function automatic logic [3:0] init_val(int i);
    logic [3:0] v;
    v = 4'(i);
    if (i == 3) v = 4'hA;
    return v;
  endfunction

  assign read_data_mem_i = mem[addr_mem_o];

  always @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (write_en_mem_o) begin
      mem[addr_mem_o] <= write_data_mem_o;
    end
  end

  task automatic chk(string name, logic [7:0] act,
                     logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(posedge clk_i) begin
    logic [3:0] e;
    #1;
    if (cpu_rvalid_o) begin
      if (exp_cpu_q.size() == 0) begin
        chk("cpu_rvalid_unexpected", 8'd1, 8'd0);
      end else begin
        e = exp_cpu_q.pop_front();
        chk("cpu_rdata", {4'h0, cpu_rdata_o}, {4'h0, e});
      end
    end
    if (dbg_rvalid_o) begin
      if (exp_dbg_q.size() == 0) begin
        chk("dbg_rvalid_unexpected", 8'd1, 8'd0);
      end else begin
        e = exp_dbg_q.pop_front();
        chk("dbg_rdata", {4'h0, dbg_rdata_o}, {4'h0, e});
      end
    end
  end

  task automatic tick;
    @(negedge clk_i);
  endtask

  task automatic cpu(logic r, logic w, logic [3:0] a,
                     logic [3:0] d);
    cpu_req_i = r; cpu_we_i = w;
    cpu_addr_i = a; cpu_wdata_i = d;
  endtask

  task automatic dbg(logic r, logic w, logic [3:0] a,
                     logic [3:0] d, logic l);
    dbg_req_i = r; dbg_we_i = w;
    dbg_addr_i = a; dbg_wdata_i = d; dbg_lock_i = l;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d;
    reset_i = 1'b1;
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0, 0);

    // reset forces grants off combinationally
    tick; cpu(1, 0, 4'd3, 0);
    #1;
    chk("rst_cpu_gnt", cpu_gnt_o, 0);
    chk("rst_read_en", read_en_mem_o, 0);
    chk("rst_addr", addr_mem_o, 0);
    tick; reset_i = 1'b0; cpu(0, 0, 0, 0);
    #1;
    chk("rst_owner", owner_o, 0);
    chk("rst_cpu_rvalid", cpu_rvalid_o, 0);
    chk("rst_dbg_rvalid", dbg_rvalid_o, 0);
    chk("rst_cpu_rdata", cpu_rdata_o, 0);
    chk("rst_dbg_rdata", dbg_rdata_o, 0);

    // CPU read of addr 3
    tick; cpu(1, 0, 4'd3, 0);
    #1;
    chk("rd_cpu_gnt", cpu_gnt_o, 1);
    chk("rd_dbg_gnt", dbg_gnt_o, 0);
    chk("rd_read_en", read_en_mem_o, 1);
    chk("rd_write_en", write_en_mem_o, 0);
    chk("rd_addr", addr_mem_o, 3);
    exp_cpu_q.push_back(4'hA);
    tick; cpu(0, 0, 0, 0);
    #1;
    chk("rd_owner_cpu", owner_o, 1);
    chk("rd_rvalid_pulse", cpu_rvalid_o, 1);
    tick;
    #1;
    chk("rd_rvalid_end", cpu_rvalid_o, 0);
    chk("rd_owner_idle", owner_o, 0);

    // CPU write addr 9 data 6
    tick; cpu(1, 1, 4'd9, 4'h6);
    #1;
    chk("wr_write_en", write_en_mem_o, 1);
    chk("wr_read_en", read_en_mem_o, 0);
    chk("wr_wdata", write_data_mem_o, 4'h6);
    chk("wr_addr", addr_mem_o, 9);
    tick; cpu(0, 0, 0, 0);
    #1;
    chk("wr_no_rvalid", cpu_rvalid_o, 0);
    chk("wr_rdata_hold", cpu_rdata_o, 4'hA);
    tick; cpu(1, 0, 4'd9, 0);
    exp_cpu_q.push_back(4'h6);
    tick; cpu(0, 0, 0, 0);

    // starvation: both request every cycle
    for (int i = 0; i < 10; i++) begin
      tick;
      cpu(1, 0, 4'd1, 0);
      dbg(1, 0, 4'd2, 0, 0);
      #1;
      d = (i == 4 || i == 9);
      chk($sformatf("st_cpu_gnt%0d", i), cpu_gnt_o, !d);
      chk($sformatf("st_dbg_gnt%0d", i), dbg_gnt_o, d);
      chk($sformatf("st_addr%0d", i), addr_mem_o,
          d ? 8'd2 : 8'd1);
      if (d) exp_dbg_q.push_back(4'd2);
      else   exp_cpu_q.push_back(4'd1);
    end
    tick; cpu(0, 0, 0, 0); dbg(0, 0, 0, 0, 0);

    // lock request ignored while CPU wins
    tick; cpu(1, 0, 4'd0, 0); dbg(1, 1, 4'd12, 4'hF, 1);
    #1;
    chk("lki_cpu_gnt", cpu_gnt_o, 1);
    chk("lki_dbg_gnt", dbg_gnt_o, 0);
    exp_cpu_q.push_back(4'd0);
    tick; cpu(0, 0, 0, 0); dbg(0, 0, 0, 0, 0);
    #1;
    chk("lki_owner", owner_o, 1);

    // debug locked write burst to addr 5
    tick; dbg(1, 1, 4'd5, 4'h7, 1);
    #1;
    chk("lk_dbg_gnt0", dbg_gnt_o, 1);
    chk("lk_write_en0", write_en_mem_o, 1);
    chk("lk_owner0", owner_o, 0);
    for (int i = 1; i < 6; i++) begin
      tick; cpu(1, 0, 4'd5, 0);
      #1;
      chk($sformatf("lk_cpu_gnt%0d", i), cpu_gnt_o, 0);
      chk($sformatf("lk_dbg_gnt%0d", i), dbg_gnt_o, 1);
      chk($sformatf("lk_owner%0d", i), owner_o, 3);
    end
    tick; dbg(0, 0, 0, 0, 0);
    #1;
    chk("lk_exit_cpu_gnt", cpu_gnt_o, 1);
    chk("lk_exit_addr", addr_mem_o, 5);
    exp_cpu_q.push_back(4'h7);
    tick; cpu(0, 0, 0, 0);

    // reset while locked with a read in flight
    tick; dbg(1, 0, 4'd4, 0, 1);
    #1;
    chk("rl_dbg_gnt", dbg_gnt_o, 1);
    exp_dbg_q.push_back(4'd4);
    tick; reset_i = 1'b1;
    #1;
    chk("rl_owner_lock", owner_o, 3);
    chk("rl_dbg_gnt_rst", dbg_gnt_o, 0);
    chk("rl_cpu_gnt_rst", cpu_gnt_o, 0);
    chk("rl_read_en_rst", read_en_mem_o, 0);
    chk("rl_addr_rst", addr_mem_o, 0);
    tick; reset_i = 1'b0; dbg(0, 0, 0, 0, 0);
    #1;
    chk("rl_owner", owner_o, 0);
    chk("rl_dbg_rvalid", dbg_rvalid_o, 0);
    chk("rl_dbg_rdata", dbg_rdata_o, 0);
    chk("rl_cpu_rvalid", cpu_rvalid_o, 0);

    // idle
    for (int i = 0; i < 3; i++) begin
      tick;
      #1;
      chk("idle_read_en", read_en_mem_o, 0);
      chk("idle_write_en", write_en_mem_o, 0);
      chk("idle_owner", owner_o, 0);
    end

    // counter stayed at 0 through idle: 4 CPU then debug
    for (int i = 0; i < 5; i++) begin
      tick;
      cpu(1, 1, 4'd8, 4'h1);
      dbg(1, 1, 4'd8, 4'h2, 0);
      #1;
      chk($sformatf("id_dbg_gnt%0d", i), dbg_gnt_o,
          (i == 4) ? 8'd1 : 8'd0);
    end
    tick; cpu(0, 0, 0, 0); dbg(0, 0, 0, 0, 0);

    tick; tick;
    chk("cpu_q_empty", 8'(exp_cpu_q.size()), 0);
    chk("dbg_q_empty", 8'(exp_dbg_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
